// File: rtl/debug_port_pair_sequencer.sv
// Issues one harness command to the Left and Right debug ports and pairs their responses.
// Each side tracks its own issued/got state; the result reports data mismatch and timeout.
module debug_port_pair_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_fcn,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              req_validLeft,
    input  logic              req_readyLeft,
    output logic              req_validRight,
    input  logic              req_readyRight,
    output logic [ADDR_W-1:0] req_bits_addr,
    output logic              req_bits_fcn,
    output logic [DATA_W-1:0] req_bits_data,
    input  logic              resp_validLeft,
    input  logic [DATA_W-1:0] resp_bits_dataLeft,
    input  logic              resp_validRight,
    input  logic [DATA_W-1:0] resp_bits_dataRight,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_dataLeft,
    output logic [DATA_W-1:0] out_dataRight,
    output logic              out_mismatch,
    output logic              out_timeout,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            stateReg, stateNext;
    logic [ADDR_W-1:0] addrReg;
    logic              fcnReg;
    logic [DATA_W-1:0] wdataReg;
    logic [TO_W-1:0]   countReg;
    logic              timeoutReg;

    logic [1:0]        reqReadyVec, respValidVec, reqValidVec;
    logic [1:0]        fireVec, captureVec, issuedVec, gotVec;
    logic [DATA_W-1:0] respDataVec [2];
    logic [DATA_W-1:0] capDataVec [2];

    logic active, acceptCmd, releaseResult, clearTxn;
    logic bothIssued, bothGot, timeoutHit;

    assign reqReadyVec    = {req_readyRight, req_readyLeft};
    assign respValidVec   = {resp_validRight, resp_validLeft};
    assign respDataVec[0] = resp_bits_dataLeft;
    assign respDataVec[1] = resp_bits_dataRight;

    assign active        = (stateReg == ISSUE) || (stateReg == WAIT);
    assign acceptCmd     = (stateReg == IDLE) && cmd_valid;
    assign releaseResult = (stateReg == DONE) && out_ready;
    // Transaction context is wiped both on a new command and when the result leaves,
    // so IDLE never shows stale request or result data.
    assign clearTxn      = acceptCmd || releaseResult;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            logic              issued;
            logic              got;
            logic [DATA_W-1:0] capData;

            assign reqValidVec[gi] = (stateReg == ISSUE) && !issued;
            assign fireVec[gi]     = reqValidVec[gi] && reqReadyVec[gi];
            // A response counts only once its request has fired (same cycle allowed); first capture wins.
            assign captureVec[gi]  = active && respValidVec[gi] && !got && (issued || fireVec[gi]);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    issued  <= 1'b0;
                    got     <= 1'b0;
                    capData <= '0;
                end else if (clearTxn) begin
                    issued  <= 1'b0;
                    got     <= 1'b0;
                    capData <= '0;
                end else begin
                    if (fireVec[gi]) issued <= 1'b1;
                    if (captureVec[gi]) begin
                        got     <= 1'b1;
                        capData <= respDataVec[gi];
                    end
                end
            end

            assign issuedVec[gi]  = issued;
            assign gotVec[gi]     = got;
            assign capDataVec[gi] = capData;
        end
    endgenerate

    assign bothIssued = &(issuedVec | fireVec);
    assign bothGot    = &(gotVec | captureVec);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) stateReg <= IDLE;
        else       stateReg <= stateNext;
    end

    always_comb begin
        stateNext  = stateReg;
        timeoutHit = 1'b0;
        cmd_ready  = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (stateReg)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) stateNext = ISSUE;
            end
            ISSUE, WAIT: begin
                // Completion beats timeout when the last response lands on the deadline cycle.
                if (bothGot) begin
                    stateNext = DONE;
                end else if (countReg == TO_W'(TIMEOUT)) begin
                    timeoutHit = 1'b1;
                    stateNext  = DONE;
                end else if ((stateReg == ISSUE) && bothIssued) begin
                    stateNext = WAIT;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addrReg    <= '0;
            fcnReg     <= 1'b0;
            wdataReg   <= '0;
            countReg   <= '0;
            timeoutReg <= 1'b0;
        end else if (acceptCmd) begin
            addrReg    <= cmd_addr;
            fcnReg     <= cmd_fcn;
            wdataReg   <= cmd_data;
            countReg   <= '0;
            timeoutReg <= 1'b0;
        end else if (releaseResult) begin
            addrReg    <= '0;
            fcnReg     <= 1'b0;
            wdataReg   <= '0;
            countReg   <= '0;
            timeoutReg <= 1'b0;
        end else if (active) begin
            if (countReg != {TO_W{1'b1}}) countReg <= countReg + 1'b1;
            if (timeoutHit) timeoutReg <= 1'b1;
        end
    end

    assign req_validLeft  = reqValidVec[0];
    assign req_validRight = reqValidVec[1];
    assign req_bits_addr  = addrReg;
    assign req_bits_fcn   = fcnReg;
    assign req_bits_data  = wdataReg;
    assign out_dataLeft   = capDataVec[0];
    assign out_dataRight  = capDataVec[1];
    assign out_mismatch   = (stateReg == DONE) && (&gotVec) && (capDataVec[0] != capDataVec[1]);
    assign out_timeout    = (stateReg == DONE) && timeoutReg;

endmodule

// File: tb/tb_debug_port_pair_sequencer.sv
// Scoreboard bench: the driver predicts each paired result from the per-side ready/response schedule,
// and a monitor checks every cycle the DUT presents out_valid.
module tb_debug_port_pair_sequencer;

    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_fcn;
    logic [31:0] cmd_addr, cmd_data;
    logic        req_validLeft, req_readyLeft, req_validRight, req_readyRight;
    logic [31:0] req_bits_addr, req_bits_data;
    logic        req_bits_fcn;
    logic        resp_validLeft, resp_validRight;
    logic [31:0] resp_bits_dataLeft, resp_bits_dataRight;
    logic        out_valid, out_ready, out_mismatch, out_timeout, busy;
    logic [31:0] out_dataLeft, out_dataRight;

    debug_port_pair_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .TO_W(4)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_fcn(cmd_fcn), .cmd_data(cmd_data),
        .req_validLeft(req_validLeft), .req_readyLeft(req_readyLeft),
        .req_validRight(req_validRight), .req_readyRight(req_readyRight),
        .req_bits_addr(req_bits_addr), .req_bits_fcn(req_bits_fcn), .req_bits_data(req_bits_data),
        .resp_validLeft(resp_validLeft), .resp_bits_dataLeft(resp_bits_dataLeft),
        .resp_validRight(resp_validRight), .resp_bits_dataRight(resp_bits_dataRight),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dataLeft(out_dataLeft), .out_dataRight(out_dataRight),
        .out_mismatch(out_mismatch), .out_timeout(out_timeout), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] dL;
        logic [31:0] dR;
        logic        mm;
        logic        to;
        int          expCyc;
        int          id;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    bit   holding = 0;
    int   nChecks = 0;
    int   nFails  = 0;
    int   txnId   = 0;

    // Schedule for the next transaction, index 0 = Left, 1 = Right.
    // rdy: first cycle after accept with req_ready high; evC: response cycles (0 = none).
    int          rdy [2];
    int          evC [2][2];
    logic [31:0] evD [2][2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] respFor(input int s, input int k);
        if (evC[s][1] == k && k != 0) return evD[s][1];
        if (evC[s][0] == k && k != 0) return evD[s][0];
        return $urandom;
    endfunction

    task automatic runTxn(input logic [31:0] a, input logic f, input logic [31:0] d, input int hold);
        int          cap [2];
        logic [31:0] capD [2];
        logic        got [2];
        int          last, doneK, w;
        exp_t        e;
        // Reference: each side keeps its first response at or after its ready cycle;
        // the result appears the cycle after the later capture, or TMO+2 cycles after accept.
        for (int s = 0; s < 2; s++) begin
            cap[s]  = 1000;
            capD[s] = '0;
            for (int j = 0; j < 2; j++)
                if (evC[s][j] != 0 && evC[s][j] >= rdy[s] && evC[s][j] < cap[s]) begin
                    cap[s]  = evC[s][j];
                    capD[s] = evD[s][j];
                end
        end
        last = (cap[0] > cap[1]) ? cap[0] : cap[1];
        if (last <= TMO + 1) begin
            doneK = last + 1;
            e.to  = 1'b0;
        end else begin
            doneK = TMO + 2;
            e.to  = 1'b1;
        end
        for (int s = 0; s < 2; s++) begin
            got[s] = (cap[s] <= doneK - 1);
            if (!got[s]) capD[s] = '0;
        end
        e.dL = capD[0];
        e.dR = capD[1];
        e.mm = got[0] && got[1] && (capD[0] != capD[1]);

        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_fcn   = f;
        cmd_data  = d;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("cmd_accepted", cmd_ready, 1);
        if (!cmd_ready) return;
        e.expCyc = cyc + doneK;
        e.id     = txnId++;
        sbq.push_back(e);

        for (int k = 1; k < doneK; k++) begin
            @(negedge clock);
            if (k == 1) begin
                cmd_valid = 1'b0;
                out_ready = 1'b0;
            end
            chk("req_validLeft", req_validLeft, (k <= rdy[0]));
            chk("req_validRight", req_validRight, (k <= rdy[1]));
            if (req_validLeft || req_validRight) begin
                chk("req_bits_addr", req_bits_addr, a);
                chk("req_bits_fcn", req_bits_fcn, f);
                chk("req_bits_data", req_bits_data, d);
            end
            chk("busy_active", busy, 1);
            chk("cmd_ready_active", cmd_ready, 0);
            req_readyLeft       = (k >= rdy[0]);
            req_readyRight      = (k >= rdy[1]);
            resp_validLeft      = (evC[0][0] == k) || (evC[0][1] == k);
            resp_validRight     = (evC[1][0] == k) || (evC[1][1] == k);
            resp_bits_dataLeft  = respFor(0, k);
            resp_bits_dataRight = respFor(1, k);
        end
        @(negedge clock);
        req_readyLeft   = 1'b0;
        req_readyRight  = 1'b0;
        resp_validLeft  = 1'b0;
        resp_validRight = 1'b0;
        // A junk command is held during DONE; it must not be taken before the handshake.
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clock);
            out_ready = (h == hold);
            cmd_valid = 1'b1;
            cmd_addr  = $urandom;
        end
    endtask

    always @(negedge clock) begin
        #2;
        if (reset) begin
            holding = 0;
        end else if (out_valid) begin
            if (!holding) begin
                chk("sb_has_entry", (sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    cur     = sbq.pop_front();
                    holding = 1;
                    chk("out_latency", cyc, cur.expCyc);
                    $display("txn %0d: dataLeft=%h dataRight=%h mismatch=%b timeout=%b",
                             cur.id, out_dataLeft, out_dataRight, out_mismatch, out_timeout);
                end
            end
            if (holding) begin
                chk("out_dataLeft", out_dataLeft, cur.dL);
                chk("out_dataRight", out_dataRight, cur.dR);
                chk("out_mismatch", out_mismatch, cur.mm);
                chk("out_timeout", out_timeout, cur.to);
                chk("cmd_ready_done", cmd_ready, 0);
                if (out_ready) holding = 0;
            end
        end
    end

    task automatic setSched(input int rl, input int rr, input int l0, input int l1, input int r0, input int r1,
                            input logic [31:0] dl0, input logic [31:0] dl1,
                            input logic [31:0] dr0, input logic [31:0] dr1);
        rdy[0] = rl;  rdy[1] = rr;
        evC[0][0] = l0; evC[0][1] = l1; evC[1][0] = r0; evC[1][1] = r1;
        evD[0][0] = dl0; evD[0][1] = dl1; evD[1][0] = dr0; evD[1][1] = dr1;
    endtask

    initial begin
        int          w;
        logic [31:0] base;
        reset = 1'b1;
        cmd_valid = 0; cmd_addr = 0; cmd_fcn = 0; cmd_data = 0;
        req_readyLeft = 0; req_readyRight = 0; resp_validLeft = 0; resp_validRight = 0;
        resp_bits_dataLeft = 0; resp_bits_dataRight = 0; out_ready = 0;
        @(negedge clock);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_valid", {req_validLeft, req_validRight}, 2'b00);
        chk("rst_req_addr", req_bits_addr, 0);
        chk("rst_out_data", {out_dataLeft, out_dataRight}, 64'h0);
        @(negedge clock);
        reset = 1'b0;

        // Minimum latency read, equal data
        setSched(1, 1, 1, 0, 1, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
        runTxn(32'h10, 1'b0, 32'h0, 0);
        // Skewed ready/response; Right response lands exactly on the deadline cycle
        setSched(1, 6, 2, 0, 9, 0, 32'h12345678, 0, 32'h12345678, 0);
        runTxn(32'h20, 1'b1, 32'hA5A5A5A5, 0);
        // Mismatch with a late duplicate Left response that must be ignored
        setSched(1, 1, 1, 2, 4, 0, 32'h1, 32'h3, 32'h2, 0);
        runTxn(32'h30, 1'b0, 32'h0, 0);
        // Right never ready, early Right response ignored -> timeout
        setSched(1, 100, 1, 0, 3, 0, 32'h11, 0, 32'h77, 0);
        runTxn(32'h40, 1'b0, 32'h0, 0);
        // Result held for four cycles with a pending command
        setSched(1, 1, 1, 0, 1, 0, 32'hCAFE0001, 0, 32'hCAFE0002, 0);
        runTxn(32'h50, 1'b1, 32'h5, 4);

        for (int i = 0; i < 40; i++) begin
            for (int s = 0; s < 2; s++) begin
                rdy[s] = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 12) : $urandom_range(1, 5);
                evC[s][0] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 9);
                evC[s][1] = (evC[s][0] != 0 && $urandom_range(0, 2) == 0) ? evC[s][0] + $urandom_range(1, 3) : 0;
                evD[s][1] = $urandom;
            end
            base = $urandom;
            evD[0][0] = base;
            evD[1][0] = $urandom_range(0, 1) ? base : $urandom;
            runTxn($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
        end

        // Reset in WAIT with Left already captured
        cmd_valid = 1'b1;
        cmd_addr  = 32'h55;
        cmd_fcn   = 1'b0;
        cmd_data  = 32'h0;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("rst_test_accept", cmd_ready, 1);
        @(negedge clock);
        cmd_valid = 1'b0; out_ready = 1'b0;
        req_readyLeft = 1'b1; req_readyRight = 1'b1;
        resp_validLeft = 1'b1; resp_bits_dataLeft = 32'hCAFEF00D;
        @(negedge clock);
        req_readyLeft = 1'b0; req_readyRight = 1'b0; resp_validLeft = 1'b0;
        chk("pre_reset_dataLeft", out_dataLeft, 32'hCAFEF00D);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("async_rst_dataLeft", out_dataLeft, 0);
        chk("async_rst_cmd_ready", cmd_ready, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_addr", req_bits_addr, 0);
        $display("reset applied mid-wait: busy=%b cmd_ready=%b dataLeft=%h", busy, cmd_ready, out_dataLeft);
        @(negedge clock);
        reset = 1'b0;
        // Post-reset: Left never answers, so its data must read 0, not the stale capture
        setSched(1, 1, 0, 0, 2, 0, 0, 0, 32'h77, 0);
        runTxn(32'h66, 1'b0, 32'h0, 0);
        cmd_valid = 1'b0;

        repeat (4) @(negedge clock);
        #3;
        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
